// File: rtl/sdm_codec_bank.sv
// NUM_CH independent channel pairs: a first-order sigma-delta DAC modulator and a boxcar ADC decimator.
// Optional build macro SDM_CODEC_BANK_DITHER_EN adds a shared LFSR +/-1 dither to every DAC.

module sdm_codec_bank #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 16,
  parameter int OSR_LOG2 = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        dac_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] dac_din,
  output logic [NUM_CH-1:0]        dac_valid_out,
  output logic [NUM_CH-1:0]        dac_bit_out,
  input  logic [NUM_CH-1:0]        adc_valid_in,
  input  logic [NUM_CH-1:0]        adc_bit_in,
  output logic [NUM_CH-1:0]        adc_valid_out,
  output logic [NUM_CH*DATA_W-1:0] adc_dout
);

`ifdef SDM_CODEC_BANK_DITHER_EN
  localparam int ACC_W = DATA_W + 3;
`else
  localparam int ACC_W = DATA_W + 2;
`endif
  localparam int OSR   = 1 << OSR_LOG2;
  localparam int SHIFT = DATA_W - 1 - OSR_LOG2;
  localparam int Y_W   = DATA_W + 2;

  localparam logic signed [ACC_W-1:0]  HALF     = {{(ACC_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [Y_W-1:0]    PCM_MAX  = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [Y_W-1:0]    OSR_Y    = Y_W'(OSR);
  localparam logic [OSR_LOG2-1:0]      CNT_LAST = {OSR_LOG2{1'b1}};

`ifdef SDM_CODEC_BANK_DITHER_EN
  // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form.
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] acc_next;
      logic signed [ACC_W-1:0] sum_next;
      logic signed [ACC_W-1:0] dith;
      logic                    bit_next;
      logic                    dac_bit_reg;
      logic                    dac_valid_reg;

      logic [OSR_LOG2-1:0]     cnt_reg;
      logic [OSR_LOG2:0]       ones_reg;
      logic [OSR_LOG2:0]       k_next;
      logic signed [Y_W-1:0]   y_lin;
      logic signed [Y_W-1:0]   y_shift;
      logic [DATA_W-1:0]       y_sat;
      logic [DATA_W-1:0]       adc_dout_reg;
      logic                    adc_valid_reg;

`ifdef SDM_CODEC_BANK_DITHER_EN
      assign dith = lfsr_reg[gi % 16] ? ACC_W'(1) : {ACC_W{1'b1}};
`else
      assign dith = '0;
`endif

      always_comb begin
        sum_next = acc_reg
                 + {{(ACC_W-DATA_W){dac_din[gi*DATA_W+DATA_W-1]}}, dac_din[gi*DATA_W +: DATA_W]}
                 + dith;
        bit_next = ~sum_next[ACC_W-1];
        acc_next = bit_next ? (sum_next - HALF) : (sum_next + HALF);
      end

      always_ff @(posedge clk) begin
        if (rst || !ch_en[gi]) begin
          acc_reg       <= '0;
          dac_bit_reg   <= 1'b0;
          dac_valid_reg <= 1'b0;
        end else begin
          dac_valid_reg <= dac_valid_in[gi];
          if (dac_valid_in[gi]) begin
            acc_reg     <= acc_next;
            dac_bit_reg <= bit_next;
          end
        end
      end

      // k includes the bit arriving this cycle; only k=OSR can exceed H-1 after scaling.
      always_comb begin
        k_next  = ones_reg + {{OSR_LOG2{1'b0}}, adc_bit_in[gi]};
        y_lin   = $signed({{(Y_W-OSR_LOG2-2){1'b0}}, k_next, 1'b0}) - OSR_Y;
        y_shift = y_lin <<< SHIFT;
        y_sat   = (y_shift > PCM_MAX) ? PCM_MAX[DATA_W-1:0] : y_shift[DATA_W-1:0];
      end

      always_ff @(posedge clk) begin
        if (rst || !ch_en[gi]) begin
          cnt_reg       <= '0;
          ones_reg      <= '0;
          adc_dout_reg  <= '0;
          adc_valid_reg <= 1'b0;
        end else begin
          adc_valid_reg <= 1'b0;
          if (adc_valid_in[gi]) begin
            if (cnt_reg == CNT_LAST) begin
              adc_dout_reg  <= y_sat;
              adc_valid_reg <= 1'b1;
              cnt_reg       <= '0;
              ones_reg      <= '0;
            end else begin
              cnt_reg  <= cnt_reg + OSR_LOG2'(1);
              ones_reg <= k_next;
            end
          end
        end
      end

      assign dac_bit_out[gi]                   = dac_bit_reg;
      assign dac_valid_out[gi]                 = dac_valid_reg;
      assign adc_valid_out[gi]                 = adc_valid_reg;
      assign adc_dout[gi*DATA_W +: DATA_W]     = adc_dout_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sdm_codec_bank.sv
// Directed self-checking bench for sdm_codec_bank (2 channels, 16-bit PCM, OSR 64).
// Exact DAC patterns apply to the default build; the dither build runs its own statistical test.

module tb_sdm_codec_bank;
  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 16;
  localparam int OSR_LOG2 = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_en;
  logic [1:0]  dac_valid_in;
  logic [31:0] dac_din;
  logic [1:0]  dac_valid_out;
  logic [1:0]  dac_bit_out;
  logic [1:0]  adc_valid_drv;
  logic [1:0]  adc_bit_drv;
  logic [1:0]  adc_valid_in;
  logic [1:0]  adc_bit_in;
  logic [1:0]  adc_valid_out;
  logic [31:0] adc_dout;
  logic        loop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Loopback routes DAC ch0 straight into ADC ch0.
  assign adc_valid_in = loop ? {adc_valid_drv[1], dac_valid_out[0]} : adc_valid_drv;
  assign adc_bit_in   = loop ? {adc_bit_drv[1], dac_bit_out[0]} : adc_bit_drv;

  sdm_codec_bank #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .OSR_LOG2(OSR_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en),
    .dac_valid_in(dac_valid_in), .dac_din(dac_din),
    .dac_valid_out(dac_valid_out), .dac_bit_out(dac_bit_out),
    .adc_valid_in(adc_valid_in), .adc_bit_in(adc_bit_in),
    .adc_valid_out(adc_valid_out), .adc_dout(adc_dout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    dac_valid_in  = '0;
    dac_din       = '0;
    adc_valid_drv = '0;
    adc_bit_drv   = '0;
    loop          = 1'b0;
    ch_en         = 2'b11;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    // Strobes held high to show reset wins.
    ch_en = 2'b11; loop = 1'b0;
    dac_valid_in = 2'b11; dac_din = 32'h1234_5678;
    adc_valid_drv = 2'b11; adc_bit_drv = 2'b11;
    rst = 1'b1;
    tick();
    total++; if (dac_valid_out !== 2'b00) begin bad++; $display("FAIL reset_dac_valid got=%b exp=00", dac_valid_out); end
    total++; if (dac_bit_out !== 2'b00) begin bad++; $display("FAIL reset_dac_bit got=%b exp=00", dac_bit_out); end
    total++; if (adc_valid_out !== 2'b00) begin bad++; $display("FAIL reset_adc_valid got=%b exp=00", adc_valid_out); end
    total++; if (adc_dout !== 32'h0) begin bad++; $display("FAIL reset_adc_dout got=%h exp=0", adc_dout); end
    rst = 1'b0;
    idle_inputs();
    $display("test_reset: done");
  endtask

  task automatic test_dac_pattern;
    logic exp_bit;
    do_reset();
    dac_din = {16'h8000, 16'h0000};
    dac_valid_in = 2'b11;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_bit = (i % 2 == 0);
      total++; if (dac_valid_out !== 2'b11) begin bad++; $display("FAIL dac_valid i=%0d got=%b exp=11", i, dac_valid_out); end
      total++; if (dac_bit_out[0] !== exp_bit) begin bad++; $display("FAIL dac_zero_bit i=%0d got=%b exp=%b", i, dac_bit_out[0], exp_bit); end
      total++; if (dac_bit_out[1] !== 1'b0) begin bad++; $display("FAIL dac_negfs_bit i=%0d got=%b exp=0", i, dac_bit_out[1]); end
    end
    dac_valid_in = 2'b00;
    tick();
    total++; if (dac_valid_out !== 2'b00) begin bad++; $display("FAIL dac_valid_idle got=%b exp=00", dac_valid_out); end
    total++; if (dac_bit_out[0] !== 1'b1) begin bad++; $display("FAIL dac_bit_hold got=%b exp=1", dac_bit_out[0]); end
    $display("test_dac_pattern: done");
  endtask

  task automatic test_dac_fullscale;
    int ones;
    do_reset();
    ones = 0;
    dac_din[15:0] = 16'h7FFF;
    dac_valid_in[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dac_bit_out[0] === 1'b1) ones++;
    end
    dac_valid_in = '0;
    total++; if (ones != 100) begin bad++; $display("FAIL dac_fs_ones got=%0d exp=100", ones); end
    total++; if (dut.gen_ch[0].acc_reg !== -100) begin bad++; $display("FAIL dac_fs_acc got=%0d exp=-100", dut.gen_ch[0].acc_reg); end
    $display("test_dac_fullscale: ones=%0d", ones);
  endtask

  task automatic adc_window(input int n_ones, input bit alt, output int npulse,
                            output int pulse_at, output logic [15:0] dout);
    npulse = 0; pulse_at = -1; dout = 'x;
    for (int j = 0; j < 64; j++) begin
      adc_valid_drv[0] = 1'b1;
      adc_bit_drv[0]   = alt ? (j % 2 == 0) : (j < n_ones);
      tick();
      if (adc_valid_out[0] === 1'b1) begin
        npulse++; pulse_at = j; dout = adc_dout[15:0];
      end
    end
    adc_valid_drv[0] = 1'b0;
    tick();
    if (adc_valid_out[0] !== 1'b0) npulse++;
  endtask

  task automatic test_adc;
    int          v_ones [4] = '{64, 0, 0, 40};
    bit          v_alt  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] v_exp  [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h2000};
    int          npulse, pulse_at;
    logic [15:0] dout;
    do_reset();
    for (int v = 0; v < 4; v++) begin
      adc_window(v_ones[v], v_alt[v], npulse, pulse_at, dout);
      total++; if (npulse != 1) begin bad++; $display("FAIL adc_pulses v=%0d got=%0d exp=1", v, npulse); end
      total++; if (pulse_at != 63) begin bad++; $display("FAIL adc_pulse_pos v=%0d got=%0d exp=63", v, pulse_at); end
      total++; if (dout !== v_exp[v]) begin bad++; $display("FAIL adc_dout v=%0d got=%h exp=%h", v, dout, v_exp[v]); end
      $display("test_adc: vector %0d dout=%h", v, dout);
    end
  endtask

  // Continues from test_adc: ch0 holds 0x2000, ch1 holds 0.
  task automatic test_disable;
    int c0_n, c0_at, c1_n, c1_at;
    idle_inputs();
    c0_n = 0; c0_at = -1; c1_n = 0; c1_at = -1;
    adc_valid_drv = 2'b11;
    adc_bit_drv   = 2'b11;
    for (int c = 0; c < 99; c++) begin
      ch_en[0] = !(c >= 30 && c < 35);
      tick();
      if (adc_valid_out[0] === 1'b1) begin c0_n++; c0_at = c; end
      if (adc_valid_out[1] === 1'b1) begin c1_n++; c1_at = c; end
      if (c == 10) begin
        total++; if (adc_dout[15:0] !== 16'h2000) begin bad++; $display("FAIL dis_hold got=%h exp=2000", adc_dout[15:0]); end
      end
      if (c == 32) begin
        total++; if (adc_dout[15:0] !== 16'h0000) begin bad++; $display("FAIL dis_clear got=%h exp=0000", adc_dout[15:0]); end
      end
    end
    idle_inputs();
    total++; if (c0_n != 1 || c0_at != 98) begin bad++; $display("FAIL dis_ch0_pulse got=%0d@%0d exp=1@98", c0_n, c0_at); end
    total++; if (adc_dout[15:0] !== 16'h7FFF) begin bad++; $display("FAIL dis_ch0_dout got=%h exp=7fff", adc_dout[15:0]); end
    total++; if (c1_n != 1 || c1_at != 63) begin bad++; $display("FAIL dis_ch1_pulse got=%0d@%0d exp=1@63", c1_n, c1_at); end
    total++; if (adc_dout[31:16] !== 16'h7FFF) begin bad++; $display("FAIL dis_ch1_dout got=%h exp=7fff", adc_dout[31:16]); end
    $display("test_disable: ch0 pulse at %0d, ch1 pulse at %0d", c0_at, c1_at);
  endtask

  task automatic test_loopback;
    int npulse;
    int d;
    do_reset();
    npulse = 0;
    loop = 1'b1;
    dac_din[15:0] = 16'd8192;
    dac_valid_in[0] = 1'b1;
    for (int c = 0; c < 64 * 5 + 4; c++) begin
      tick();
      if (adc_valid_out[0] === 1'b1) begin
        npulse++;
        d = int'($signed(adc_dout[15:0])) - 8192;
        if (npulse > 1) begin
          total++; if (d > 512 || d < -512) begin bad++; $display("FAIL loop_dout n=%0d got=%0d exp=8192+-512", npulse, $signed(adc_dout[15:0])); end
        end
      end
    end
    idle_inputs();
    total++; if (npulse != 5) begin bad++; $display("FAIL loop_pulses got=%0d exp=5", npulse); end
    $display("test_loopback: %0d windows", npulse);
  endtask

  task automatic test_rst_mid;
    do_reset();
    dac_valid_in[0] = 1'b1;
    adc_valid_drv[1] = 1'b1;
    adc_bit_drv[1] = 1'b1;
    for (int c = 0; c < 71; c++) tick();
    total++; if (adc_dout[31:16] !== 16'h7FFF) begin bad++; $display("FAIL rmid_pre_dout got=%h exp=7fff", adc_dout[31:16]); end
    rst = 1'b1;
    tick();
    total++; if (dac_valid_out !== 2'b00 || dac_bit_out !== 2'b00) begin bad++; $display("FAIL rmid_dac got=%b/%b exp=00/00", dac_valid_out, dac_bit_out); end
    total++; if (adc_valid_out !== 2'b00 || adc_dout !== 32'h0) begin bad++; $display("FAIL rmid_adc got=%b/%h exp=00/0", adc_valid_out, adc_dout); end
    rst = 1'b0;
    tick();
    total++; if (dac_valid_out[0] !== 1'b1 || dac_bit_out[0] !== 1'b1) begin bad++; $display("FAIL rmid_restart1 got=%b/%b exp=1/1", dac_valid_out[0], dac_bit_out[0]); end
    tick();
    total++; if (dac_bit_out[0] !== 1'b0) begin bad++; $display("FAIL rmid_restart2 got=%b exp=0", dac_bit_out[0]); end
    idle_inputs();
    $display("test_rst_mid: done");
  endtask

`ifdef SDM_CODEC_BANK_DITHER_EN
  task automatic dither_run(output logic [63:0] bits, output int ones);
    do_reset();
    ones = 0;
    dac_valid_in[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      bits[i] = dac_bit_out[0];
      if (dac_bit_out[0] === 1'b1) ones++;
    end
    idle_inputs();
  endtask

  task automatic test_dither;
    logic [63:0] run1, run2;
    int ones1, ones2;
    dither_run(run1, ones1);
    dither_run(run2, ones2);
    total++; if (ones1 < 30 || ones1 > 34) begin bad++; $display("FAIL dith_ones got=%0d exp=32+-2", ones1); end
    total++; if (run1 === 64'h5555_5555_5555_5555) begin bad++; $display("FAIL dith_pattern got=%h exp=not-alternating", run1); end
    total++; if (run1 !== run2) begin bad++; $display("FAIL dith_repeat got=%h exp=%h", run2, run1); end
    $display("test_dither: ones=%0d", ones1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_adc();
    test_disable();
`ifdef SDM_CODEC_BANK_DITHER_EN
    test_dither();
`else
    test_dac_pattern();
    test_dac_fullscale();
    test_loopback();
    test_rst_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdm_codec_bank.md
# sdm_codec_bank

Parametrised multi-channel sigma-delta codec bank with NUM_CH independent channel pairs. Each pair has:
- a DAC path: first-order modulator, signed PCM in, 1-bit stream out;
- an ADC path: boxcar decimator, 1-bit stream in, signed PCM out.

It replaces fixed two-channel top-level instantiation with one generic block that adds per-channel enable, a configurable oversampling ratio, and output saturation. It sits between the audio sample interface and the 1-bit pad/stream interface.

## Interface
Parameters:
- NUM_CH, 2, number of channel pairs (1..16)
- DATA_W, 16, PCM sample width (signed two's complement)
- OSR_LOG2, 6, log2 of decimation ratio OSR; legal range 1..DATA_W-1

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- ch_en  in  NUM_CH  per-channel enable; bit i gates DAC i and ADC i
- dac_valid_in  in  NUM_CH  per-channel sample strobe
- dac_din  in  NUM_CH*DATA_W  packed PCM; channel i at [i*DATA_W +: DATA_W]
- dac_valid_out  out  NUM_CH  strobe for dac_bit_out
- dac_bit_out  out  NUM_CH  modulator bit, 1 = +FS
- adc_valid_in  in  NUM_CH  per-channel bit strobe
- adc_bit_in  in  NUM_CH  1-bit stream input
- adc_valid_out  out  NUM_CH  one-cycle strobe per decimated sample
- adc_dout  out  NUM_CH*DATA_W  packed decimated PCM, same packing as dac_din

## Operation
- Reset (rst=1 at a clk edge) clears everything:
  - all outputs go to 0;
  - every acc, cnt and ones register goes to 0.
  - Reset has priority over all other inputs.
- Channel disable (ch_en[i]=0):
  - acc, cnt, ones and the channel's outputs clear to 0 on the next edge;
  - valid_in for that channel is ignored;
  - a partial ADC window is discarded, and decimation restarts at sample 0 once re-enabled.
- DAC channel i, per accepted dac_valid_in[i]:
  - acc is signed DATA_W+2 bits; H = 2^(DATA_W-1).
  - v = acc + sext(din)
  - bit = (v >= 0)
  - acc <= v - (bit ? H : -H)
  - dac_bit_out[i] <= bit
  - Cycles with no strobe hold acc and dac_bit_out.
- ADC channel i, per accepted adc_valid_in[i]:
  - cnt is OSR_LOG2 bits; ones is OSR_LOG2+1 bits.
  - ones += adc_bit_in[i]; cnt += 1.
  - On the OSR-th bit (cnt == OSR-1):
    - k = final ones count, including the current bit;
    - y = (2k - OSR) << (DATA_W-1-OSR_LOG2);
    - saturate y to [-H, H-1], so k=OSR gives H-1 and k=0 gives -H;
    - adc_dout[i] <= y; cnt and ones restart at 0.
  - adc_dout holds its value between windows.
- Channels are fully independent. DAC and ADC paths never interact. Simultaneous strobes on all channels are processed in the same cycle.
- Arithmetic: no wrap is possible in acc (|acc| <= H). Only the k=OSR case saturates.

## Timing
- DAC latency: dac_valid_out[i] and dac_bit_out[i] update on the edge after the edge sampling dac_valid_in[i]=1. Latency is 1 cycle; throughput is 1 sample per clock.
- dac_valid_out[i] is 1 exactly for the cycles following accepted strobes and is 0 otherwise.
- ADC latency: adc_valid_out[i] pulses for 1 cycle on the edge after the OSR-th accepted bit. Back-to-back windows at full rate give one pulse every OSR cycles.
- No backpressure. Inputs are accepted whenever ch_en[i]=1 and rst=0.
- If rst or ch_en[i]=0 is asserted in the same cycle as a valid, the valid is dropped and no valid_out follows.

## Configuration
- SDM_CODEC_BANK_DITHER_EN defined:
  - one shared 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1;
  - seeded 16'hACE1 on rst and advanced every clk;
  - DAC channel i adds d = LFSR[i%16] ? +1 : -1 into v, so v = acc + sext(din) + d;
  - acc is widened by 1 bit to absorb the dither.
- Undefined: no LFSR and d=0. Exact behaviour is as in Operation, which is the baseline for all tests below.

## Test plan
- Defaults, macro undefined, ch_en=all 1:
  - dac_din ch0 = 0, strobe every cycle -> dac_bit_out ch0 = 1,0,1,0,... starting 1 cycle after first strobe.
  - dac_din ch1 = -32768 -> ch1 bits all 0.
  - dac_din ch0 = +32767, 100 strobes -> all 100 bits are 1; the internal acc, checked via hierarchical probe, reaches -100.
- ADC ch0, 64 bits all 1 -> one adc_valid_out pulse, adc_dout = 32767 (saturated). 64 zeros -> -32768. Alternating 1/0 -> 0. 40 ones + 24 zeros -> (80-64)<<9 = 8192.
- Loopback: feed dac_bit_out ch0 into adc_bit_in ch0 with dac_din = 8192 -> after the first window, each adc_dout is within ±512 of 8192.
- Drop ch_en[0] after 30 ADC bits, re-enable, then send 64 ones -> adc_dout = 32767 after exactly 64 bits, and no pulse during disable. Also check ch1 is unaffected throughout.
- Assert rst mid-stream for 1 cycle -> all outputs are 0 the next cycle, and the DAC with din=0 restarts the pattern with bit 1.
- Macro defined, din=0 for 64 strobes -> the count of ones is 32±2, the bit pattern differs from strict alternation, and is identical across two runs after rst.
